// File: rtl/key_pio_pkg.sv
// key_pio_pkg: shared register addresses, edge-mode encoding and the
// per-bit edge qualification helper for the key PIO capture block.
package key_pio_pkg;

  // Avalon-MM word addresses of the four slave registers.
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_TSTAMP  = 2'd3;

  // Which transitions of the debounced level are captured.
  typedef enum logic [1:0] {
    EDGE_FALL = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

  // True when the transition prev -> cur qualifies under the given mode.
  // An unused encoding (3) captures nothing.
  function automatic logic edge_hit(input edge_mode_e mode,
                                    input logic       cur,
                                    input logic       prev);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_FALL: hit = prev & ~cur;
      EDGE_RISE: hit = ~prev & cur;
      EDGE_ANY:  hit = prev ^ cur;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/key_pio_capture_debounce.sv
// key_debounce: one input pin -> 2-flop synchroniser -> hold counter ->
// debounced stable level. A new synchronised level must persist for
// DEBOUNCE_CYCLES consecutive cycles before it is accepted; any shorter
// excursion clears the counter and is discarded. The counter saturates
// rather than wrapping.
module key_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   DB_CNT_W        = 16,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic stable
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                stable_q, stable_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: synchroniser shift, counter run/clear, stable update.
  always_comb begin
    sync1_d  = pin;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset discards any partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= IDLE_LEVEL;
      sync2_q  <= IDLE_LEVEL;
      stable_q <= IDLE_LEVEL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/key_pio_capture.sv
// key_pio_capture: WIDTH-channel debounced key/switch input port with
// sticky edge capture, maskable level interrupt and a 4-word Avalon-MM
// slave. Optional build macro KEY_PIO_TIMESTAMP_EN adds a free-running
// cycle counter whose value is latched whenever a capture bit newly sets;
// without it address 3 reads 0.
//
// Bus protocol: the slave never stalls. A write takes effect on the clock
// edge that samples avs_write. A read is accepted on the edge that samples
// avs_read and avs_readdata presents the value one cycle later, then holds
// until the next read. Reads have no side effects.
module key_pio_capture
  import key_pio_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   DB_CNT_W        = 16,
  parameter int   EDGE_MODE       = 0,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] key_export,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  localparam edge_mode_e MODE = edge_mode_e'(2'(EDGE_MODE));

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d_q, stable_d_d;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic [31:0]      tstamp_val;

  // One synchroniser/debouncer per pin.
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_CNT_W        (DB_CNT_W),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_db (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .pin    (key_export[i]),
      .stable (stable[i])
    );
  end

  // High write-data bits have no register behind them.
  if (WIDTH < 32) begin : g_wd_unused
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:WIDTH];
  end

  // Edge qualification and W1C decode.
  always_comb begin
    edge_set = '0;
    edge_clr = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_set[i] = edge_hit(MODE, stable[i], stable_d_q[i]);
    end
    if (avs_write && avs_address == ADDR_EDGECAP) begin
      edge_clr = avs_writedata[WIDTH-1:0];
    end
  end

  // Register next-state: a capture set beats a same-cycle clear.
  always_comb begin
    stable_d_d = stable;
    edgecap_d  = (edgecap_q & ~edge_clr) | edge_set;
    irqmask_d  = irqmask_q;
    if (avs_write && avs_address == ADDR_IRQMASK) begin
      irqmask_d = avs_writedata[WIDTH-1:0];
    end
    irq_d = |(edgecap_q & irqmask_q);
  end

  // Read mux; returns register contents before this cycle's updates.
  always_comb begin
    readdata_d = readdata_q;
    if (avs_read) begin
      case (avs_address)
        ADDR_DATA:    readdata_d = 32'(stable);
        ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
        ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
        ADDR_TSTAMP:  readdata_d = tstamp_val;
        default:      readdata_d = 32'd0;
      endcase
    end
  end

  // Control/status registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_d_q <= {WIDTH{IDLE_LEVEL}};
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      stable_d_q <= stable_d_d;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

`ifdef KEY_PIO_TIMESTAMP_EN
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] tstamp_q, tstamp_d;

  // Free-running counter; latch it when any capture bit goes 0 -> 1.
  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    tstamp_d = tstamp_q;
    if (|(edge_set & ~edgecap_q)) begin
      tstamp_d = cycle_q;
    end
  end

  // Timestamp registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cycle_q  <= '0;
      tstamp_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      tstamp_q <= tstamp_d;
    end
  end

  assign tstamp_val = tstamp_q;
`else
  assign tstamp_val = 32'd0;
`endif

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_key_pio_capture.sv
// tb_key_pio_capture: directed test of key_pio_capture with WIDTH=4,
// DEBOUNCE_CYCLES=4, falling-edge capture. Reads push their expected data
// into a queue; a monitor pops and compares one cycle after each read.
module tb_key_pio_capture;

  localparam int WIDTH = 4;
  localparam int DB    = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] key;
  logic [1:0]       addr;
  logic             rd;
  logic             wr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             irq;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen;

  key_pio_capture #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DB),
    .DB_CNT_W        (4),
    .EDGE_MODE       (0),
    .IDLE_LEVEL      (1'b1)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .key_export    (key),
    .avs_address   (addr),
    .avs_read      (rd),
    .avs_write     (wr),
    .avs_writedata (wdata),
    .avs_readdata  (rdata),
    .irq           (irq)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: a read sampled on a rising edge is checked at the next falling edge.
  always @(posedge clk) rd_seen <= rd;

  always @(negedge clk) begin
    if (rd_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got 0x%08h with nothing expected", rdata);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL %s: readdata=0x%08h expected 0x%08h", n, rdata, e);
        end
      end
    end
  end

  // Driver tasks (called at a falling edge, return at a falling edge).
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string n);
    addr = a;
    rd   = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic check_irq(input logic e, input string n);
    checks++;
    if (irq !== e) begin
      errors++;
      $display("FAIL %s: irq=%0b expected %0b", n, irq, e);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads never answered, expected 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic apply_reset();
    key   = 4'hF;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
  endtask

  logic [31:0] ts_exp;

  initial begin
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = 2'd0;
    wdata = 32'd0;
    key   = 4'hF;
    rst_n = 1'b0;
    @(negedge clk);
    apply_reset();

    // Reset state.
    check_irq(1'b0, "reset_irq");
    bus_read(2'd0, 32'h0000_000F, "reset_data");
    bus_read(2'd1, 32'h0, "reset_irqmask");
    bus_read(2'd2, 32'h0, "reset_edgecap");
    bus_read(2'd3, 32'h0, "reset_tstamp");
    idle(2);

    // Falling edge on key[1]: stable after 6 cycles, capture after 7.
    key[1] = 1'b0;
    idle(5);
    bus_read(2'd0, 32'h0000_000F, "data_before_stable");
    bus_read(2'd2, 32'h0, "edgecap_cycle7_preset");
    bus_read(2'd2, 32'h0000_0002, "edgecap_cycle8");
    bus_read(2'd0, 32'h0000_000D, "data_after_stable");
    check_irq(1'b0, "irq_masked_off");
    idle(2);
    check_irq(1'b0, "irq_masked_off_later");

    // Clear, enable mask bit1, confirm rising edge is not captured.
    bus_write(2'd2, 32'h2);
    bus_write(2'd1, 32'h2);
    bus_read(2'd2, 32'h0, "edgecap_after_w1c");
    check_irq(1'b0, "irq_after_clear");
    key[1] = 1'b1;
    idle(10);
    bus_read(2'd2, 32'h0, "rising_not_captured");
    bus_read(2'd0, 32'h0000_000F, "data_released");
    idle(2);

    // Repeat falling edge with mask: irq one cycle after capture.
    key[1] = 1'b0;
    idle(7);
    check_irq(1'b0, "irq_at_capture_cycle");
    idle(1);
    check_irq(1'b1, "irq_after_capture");
    bus_write(2'd2, 32'h2);
    check_irq(1'b1, "irq_same_cycle_as_w1c");
    idle(1);
    check_irq(1'b0, "irq_cleared");
    bus_read(2'd2, 32'h0, "edgecap_cleared");
    key[1] = 1'b1;
    idle(10);

    // 3-cycle glitch on key[0] is filtered.
    key[0] = 1'b0;
    idle(3);
    key[0] = 1'b1;
    idle(10);
    bus_read(2'd0, 32'h0000_000F, "glitch3_data");
    bus_read(2'd2, 32'h0, "glitch3_no_capture");

    // 4-cycle pulse is exactly long enough to be accepted.
    key[0] = 1'b0;
    idle(4);
    key[0] = 1'b1;
    idle(15);
    bus_read(2'd2, 32'h0000_0001, "pulse4_captured");
    bus_read(2'd0, 32'h0000_000F, "pulse4_data_back");
    check_irq(1'b0, "irq_bit0_unmasked");
    bus_write(2'd2, 32'h1);
    idle(2);

    // W1C on bit2 in the very cycle bit2 captures: set wins.
    key[2] = 1'b0;
    idle(6);
    bus_write(2'd2, 32'h4);
    bus_read(2'd2, 32'h0000_0004, "w1c_vs_set");
    bus_write(2'd2, 32'h4);
    bus_read(2'd2, 32'h0, "w1c_bit2_later");

    // DATA ignores writes; IRQMASK keeps only WIDTH bits.
    bus_write(2'd0, 32'h0);
    bus_read(2'd0, 32'h0000_000B, "data_write_ignored");
    bus_read(2'd1, 32'h0000_0002, "irqmask_readback");
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, 32'h0000_000F, "irqmask_width");
    bus_write(2'd1, 32'h0);
    key[2] = 1'b1;
    idle(10);
    drain();

    // Timestamp: key change after edge 994 captures on edge 1001 (count 1000).
    apply_reset();
    idle(994);
    key[3] = 1'b0;
    idle(10);
`ifdef KEY_PIO_TIMESTAMP_EN
    ts_exp = 32'd1000;
`else
    ts_exp = 32'd0;
`endif
    bus_read(2'd3, ts_exp, "tstamp");
    bus_read(2'd2, 32'h0000_0008, "tstamp_edgecap");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
